clk_period_monitor: RTL and testbench
=====================================

// Module: clk_period_monitor
// PURPOSE
// - Receive-side companion to the bench/clock generators: measures the period (and
//   optionally the high time) of a slow clock or strobe sig_i, counted in cycles of clk.
// - Sits on any generated clock or enable: divider outputs, tick strobes, external refs.
// - Checks each period against a window and flags short, long and stuck (timeout) periods.
// - Asserts locked_o after LOCK_N consecutive in-window periods.
// PARAMETERS
// - CNT_W       16    width of the period/high-time counters and outputs
// - MIN_PERIOD  2     smallest legal period, in clk cycles (inclusive)
// - MAX_PERIOD  1000  largest legal period, in clk cycles (inclusive)
// - TIMEOUT     4096  clk cycles without a rising edge before timeout_o; must be > MAX_PERIOD
// - LOCK_N      4     consecutive in-window periods required to assert locked_o
// PORTS
// - clk          in   1      single clock for all logic
// - rst          in   1      asynchronous, active-high reset
// - en           in   1      monitor enable; 0 forces IDLE
// - sig_i        in   1      monitored signal, asynchronous to clk
// - period_o     out  CNT_W  last measured rising-to-rising period
// - high_o       out  CNT_W  last measured high time (MON_DUTY_EN only, else 0)
// - valid_o      out  1      one-cycle pulse: period_o/high_o updated this cycle
// - err_short_o  out  1      one-cycle pulse with valid_o when period < MIN_PERIOD
// - err_long_o   out  1      one-cycle pulse with valid_o when period > MAX_PERIOD
// - timeout_o    out  1      level: no rising edge for TIMEOUT cycles
// - locked_o     out  1      level: LOCK_N consecutive good periods seen
// BEHAVIOUR
// - Reset: all outputs 0, counters 0, state IDLE.
// - Input path: 2-flop synchroniser, then edge detect. rise = sync & ~sync_d.
// - States:
//   - IDLE: entered on en=0 (any state, same cycle) or reset; outputs hold except
//     locked_o/timeout_o, which clear. Moves to ARM when en=1.
//   - ARM: waits for the first rise. Sets cnt=1 and goes to MEASURE. No valid_o on
//     the first edge. TIMEOUT cycles without a rise -> timeout_o=1; stays in ARM.
//   - MEASURE: cnt increments each cycle, saturating at 2^CNT_W-1.
//     - On a rise: period_o<=cnt, valid_o=1, error pulses per window; cnt<=1.
//     - Example: 8-cycle square wave -> period_o=8.
//   - Timeout: cnt reaches TIMEOUT -> timeout_o=1, locked_o=0, good count cleared,
//     go to ARM. timeout_o clears on the next rise.
// - Lock: good counter increments on each in-window valid_o and saturates at LOCK_N.
//   - Any error pulse or timeout clears it and drops locked_o the next cycle.
//   - locked_o=1 the cycle after the LOCK_N-th good valid_o.
// - Latency: valid_o is 3 clk cycles after the sig_i rising transition (2 sync + 1 register).
// - Simultaneous rise and cnt==TIMEOUT: the rise wins; it is measured, and no timeout.
// - Reset mid-measurement: partial count is discarded and no valid_o is issued.
// CONFIGURATION
// - MON_DUTY_EN defined:
//   - hcnt counts cycles while sync==1; cleared on rise, frozen on fall.
//   - high_o<=hcnt at each rise-triggered valid_o.
// - MON_DUTY_EN undefined: no hcnt logic; high_o tied to 0.
// STRUCTURE
// - Package clk_mon_pkg: mon_state_e (IDLE, ARM, MEASURE) and saturation helper function.
// - Sub-module sync_edge_det: 2-flop synchroniser + registered rise/fall pulses,
//   async active-high reset.
// TESTING
// - Square wave, 4 high / 4 low, en=1 -> first valid_o after second rise.
//   period_o=8, no errors, locked_o=1 after 4th good valid_o.
// - MON_DUTY_EN, 3 high / 7 low -> period_o=10, high_o=3 on every valid_o.
// - Period 1200 with MAX_PERIOD=1000 -> err_long_o with valid_o, locked_o drops.
//   Period 8 restored -> relock after 4 periods.
// - sig_i held 0 after lock -> timeout_o=1 at cnt==4096, locked_o=0.
//   Next rise clears timeout_o; no valid_o on that edge.
// - en=0 mid-period, then en=1 -> no valid_o until two rises; locked_o cleared in IDLE.
// - rst pulsed mid-MEASURE (async, not clock-aligned) -> all outputs 0 immediately;
//   measurement restarts in ARM.

Source files
------------

// File: rtl/clk_mon_pkg.sv
// ---------------------------------------------------------------------------
// clk_mon_pkg
//   Shared types and helpers for the clock/strobe period monitor.
//   - mon_state_e : monitor FSM states (IDLE, ARM, MEASURE)
//   - win_chk_t   : result of a period window check (short / long flags)
//   - sat_inc     : saturating increment, evaluated on 32-bit operands so a
//                   single helper serves counters of any width up to 32 bits
//   - check_window: classifies a measured period against [min, max]
// ---------------------------------------------------------------------------
package clk_mon_pkg;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    ARM     = 2'd1,
    MEASURE = 2'd2
  } mon_state_e;

  typedef struct packed {
    logic too_short;
    logic too_long;
  } win_chk_t;

  // Returns v+1, or max once v has reached max.
  function automatic logic [31:0] sat_inc(input logic [31:0] v,
                                          input logic [31:0] max);
    return (v >= max) ? max : v + 32'd1;
  endfunction

  // Window bounds are inclusive on both ends.
  function automatic win_chk_t check_window(input logic [31:0] period,
                                            input logic [31:0] min_p,
                                            input logic [31:0] max_p);
    win_chk_t r;
    r.too_short = (period < min_p);
    r.too_long  = (period > max_p);
    return r;
  endfunction

endpackage

// File: rtl/sync_edge_det.sv
// ---------------------------------------------------------------------------
// sync_edge_det
//   Two-flop synchroniser for an asynchronous input, followed by registered
//   rising/falling edge pulses derived from the synchronised level.
//
//   Ports
//     clk   in   1  sampling clock
//     rst   in   1  asynchronous, active-high reset
//     d     in   1  asynchronous input
//     sync  out  1  synchronised level (second flop)
//     rise  out  1  one-cycle pulse, high in the first cycle sync==1
//     fall  out  1  one-cycle pulse, high in the first cycle sync==0
//
//   rise is registered from the flop pair (s1 & ~s2), so it is aligned with
//   the cycle in which sync first reads 1: equivalent to sync & ~sync_d
//   without a third flop on the level path.
// ---------------------------------------------------------------------------
module sync_edge_det (
  input  logic clk,
  input  logic rst,
  input  logic d,
  output logic sync,
  output logic rise,
  output logic fall
);

  logic s1;
  logic s2;

  // NOTE: sequential state uses non-blocking assignments so every flop
  // samples the pre-edge value of its neighbour; blocking here would
  // collapse the synchroniser chain into a single stage.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      s1   <= 1'b0;
      s2   <= 1'b0;
      rise <= 1'b0;
      fall <= 1'b0;
    end else begin
      s1   <= d;
      s2   <= s1;
      rise <= s1 & ~s2;
      fall <= ~s1 & s2;
    end
  end

  assign sync = s2;

endmodule

// File: rtl/clk_period_monitor.sv
// ---------------------------------------------------------------------------
// clk_period_monitor
//   Measures the rising-to-rising period of a slow clock or strobe (sig_i) in
//   cycles of clk, checks it against an inclusive [MIN_PERIOD, MAX_PERIOD]
//   window, flags stuck inputs with a timeout and reports lock after LOCK_N
//   consecutive in-window periods.
//
//   Build option
//     MON_DUTY_EN  when defined, also measures the high time of sig_i and
//                  reports it on high_o; otherwise high_o is tied to 0.
//
//   Parameters
//     CNT_W       width of period/high-time counters and outputs
//     MIN_PERIOD  smallest legal period (inclusive), clk cycles
//     MAX_PERIOD  largest legal period (inclusive), clk cycles
//     TIMEOUT     clk cycles without a rising edge before timeout_o
//                 (must exceed MAX_PERIOD)
//     LOCK_N      consecutive in-window periods required for locked_o
//
//   Ports
//     clk          in   1      single clock for all logic
//     rst          in   1      asynchronous, active-high reset
//     en           in   1      monitor enable; 0 forces IDLE
//     sig_i        in   1      monitored signal, asynchronous to clk
//     period_o     out  CNT_W  last measured rising-to-rising period
//     high_o       out  CNT_W  last measured high time (MON_DUTY_EN only)
//     valid_o      out  1      pulse: period_o/high_o updated this cycle
//     err_short_o  out  1      pulse with valid_o: period < MIN_PERIOD
//     err_long_o   out  1      pulse with valid_o: period > MAX_PERIOD
//     timeout_o    out  1      level: no rising edge for TIMEOUT cycles
//     locked_o     out  1      level: LOCK_N consecutive good periods seen
//
//   Latency: valid_o rises 3 clk cycles after the sig_i rising transition
//   (2 synchroniser flops + 1 output register).
// ---------------------------------------------------------------------------
module clk_period_monitor
  import clk_mon_pkg::*;
#(
  parameter int unsigned CNT_W      = 16,
  parameter int unsigned MIN_PERIOD = 2,
  parameter int unsigned MAX_PERIOD = 1000,
  parameter int unsigned TIMEOUT    = 4096,
  parameter int unsigned LOCK_N     = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             en,
  input  logic             sig_i,
  output logic [CNT_W-1:0] period_o,
  output logic [CNT_W-1:0] high_o,
  output logic             valid_o,
  output logic             err_short_o,
  output logic             err_long_o,
  output logic             timeout_o,
  output logic             locked_o
);

  localparam int unsigned GOOD_W   = $clog2(LOCK_N + 1);
  localparam logic [31:0] CNT_MAX  = 32'((33'd1 << CNT_W) - 33'd1);
  localparam logic [31:0] GOOD_MAX = 32'(LOCK_N);

  mon_state_e        state;
  logic [CNT_W-1:0]  cnt;
  logic [GOOD_W-1:0] good;
  logic [CNT_W-1:0]  cnt_inc;
  logic [GOOD_W-1:0] good_inc;
  logic              at_timeout;
  win_chk_t          win;

  logic sync;
  logic rise;
  logic fall;

  sync_edge_det u_sync_edge_det (
    .clk  (clk),
    .rst  (rst),
    .d    (sig_i),
    .sync (sync),
    .rise (rise),
    .fall (fall)
  );

  assign cnt_inc    = CNT_W'(sat_inc(32'(cnt), CNT_MAX));
  assign good_inc   = GOOD_W'(sat_inc(32'(good), GOOD_MAX));
  assign at_timeout = (cnt == CNT_W'(TIMEOUT));
  assign win        = check_window(32'(cnt), 32'(MIN_PERIOD), 32'(MAX_PERIOD));

  // -------------------------------------------------------------------------
  // Main FSM. cnt doubles as the period counter in MEASURE and as the
  // no-edge watchdog in ARM. locked_o follows the good counter with one
  // cycle of delay, so an error drops lock the cycle after its pulse while
  // timeout and disable clear lock directly.
  // -------------------------------------------------------------------------
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state       <= IDLE;
      cnt         <= '0;
      good        <= '0;
      period_o    <= '0;
      valid_o     <= 1'b0;
      err_short_o <= 1'b0;
      err_long_o  <= 1'b0;
      timeout_o   <= 1'b0;
      locked_o    <= 1'b0;
    end else begin
      // NOTE: pulses default low here and are raised only in the branch that
      // produces them, which keeps each pulse exactly one cycle wide.
      valid_o     <= 1'b0;
      err_short_o <= 1'b0;
      err_long_o  <= 1'b0;
      locked_o    <= (good == GOOD_W'(LOCK_N));

      if (!en) begin
        // Disable takes priority over every state; period_o/high_o hold.
        state     <= IDLE;
        cnt       <= '0;
        good      <= '0;
        timeout_o <= 1'b0;
        locked_o  <= 1'b0;
      end else begin
        case (state)
          IDLE: begin
            cnt   <= '0;
            state <= ARM;
          end

          ARM: begin
            if (rise) begin
              // First edge only starts a measurement; nothing to report yet.
              cnt       <= CNT_W'(1);
              timeout_o <= 1'b0;
              state     <= MEASURE;
            end else begin
              cnt <= cnt_inc;
              if (at_timeout) begin
                timeout_o <= 1'b1;
                good      <= '0;
                locked_o  <= 1'b0;
              end
            end
          end

          MEASURE: begin
            // A rise in the same cycle as the timeout count wins.
            if (rise) begin
              period_o    <= cnt;
              valid_o     <= 1'b1;
              err_short_o <= win.too_short;
              err_long_o  <= win.too_long;
              good        <= (win.too_short || win.too_long) ? '0 : good_inc;
              cnt         <= CNT_W'(1);
            end else if (at_timeout) begin
              timeout_o <= 1'b1;
              locked_o  <= 1'b0;
              good      <= '0;
              cnt       <= '0;
              state     <= ARM;
            end else begin
              cnt <= cnt_inc;
            end
          end

          default: state <= IDLE;
        endcase
      end
    end
  end

`ifdef MON_DUTY_EN
  // -------------------------------------------------------------------------
  // High-time measurement. hcnt restarts at 1 on the rise (that cycle is
  // already high), counts while the synchronised level is high and freezes
  // once it falls, so at the next rise it holds the previous high time.
  // -------------------------------------------------------------------------
  logic [CNT_W-1:0] hcnt;
  logic             measure_rise;
  logic             unused_edge;

  assign measure_rise = en && (state == MEASURE) && rise;
  assign unused_edge  = fall;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      hcnt   <= '0;
      high_o <= '0;
    end else begin
      if (rise) begin
        hcnt <= CNT_W'(1);
      end else if (sync) begin
        hcnt <= CNT_W'(sat_inc(32'(hcnt), CNT_MAX));
      end
      if (measure_rise) begin
        high_o <= hcnt;
      end
    end
  end
`else
  // Without duty measurement the level and falling edge have no consumer.
  logic unused_edge;

  assign unused_edge = sync ^ fall;
  assign high_o      = '0;
`endif

endmodule

// File: tb/tb_clk_period_monitor.sv
// ---------------------------------------------------------------------------
// tb_clk_period_monitor
//   Directed bench for clk_period_monitor with default parameters
//   (MIN 2, MAX 1000, TIMEOUT 4096, LOCK_N 4). sig_i is driven on falling
//   clk edges, so a high/low pair of h/l calls yields a rise-to-rise period
//   of exactly h+l clk cycles. A monitor logs every valid_o pulse together
//   with locked_o in that cycle and in the following one.
// ---------------------------------------------------------------------------
module tb_clk_period_monitor;

`ifdef MON_DUTY_EN
  localparam bit DUTY = 1'b1;
`else
  localparam bit DUTY = 1'b0;
`endif

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        en  = 1'b0;
  logic        sig_i = 1'b0;
  logic [15:0] period_o;
  logic [15:0] high_o;
  logic        valid_o;
  logic        err_short_o;
  logic        err_long_o;
  logic        timeout_o;
  logic        locked_o;

  clk_period_monitor dut (
    .clk         (clk),
    .rst         (rst),
    .en          (en),
    .sig_i       (sig_i),
    .period_o    (period_o),
    .high_o      (high_o),
    .valid_o     (valid_o),
    .err_short_o (err_short_o),
    .err_long_o  (err_long_o),
    .timeout_o   (timeout_o),
    .locked_o    (locked_o)
  );

  always #5 clk = ~clk;

  int total = 0;
  int bad   = 0;

  task automatic check(input string tag, input int got, input int exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got %0d, expected %0d", tag, got, exp);
    end
  endtask

  // ---------------- valid_o monitor (sole writer of its variables) --------
  typedef struct {
    int per;
    int hi;
    bit es;
    bit el;
    bit lk;
    bit lkn;
  } ent_t;

  ent_t vq[$];
  int   cyc_cnt    = 0;
  int   last_valid = 0;
  bit   fill_next  = 1'b0;
  bit   to_seen    = 1'b0;
  int   to_cyc     = 0;
  bit   to_lk      = 1'b1;

  always @(negedge clk) begin
    cyc_cnt++;
    if (fill_next) vq[vq.size()-1].lkn = locked_o;
    fill_next = valid_o;
    if (valid_o) begin
      vq.push_back('{int'(period_o), int'(high_o), err_short_o, err_long_o,
                     locked_o, 1'b0});
      last_valid = cyc_cnt;
    end
    if (timeout_o && !to_seen) begin
      to_seen = 1'b1;
      to_cyc  = cyc_cnt;
      to_lk   = locked_o;
    end
  end

  // ---------------- stimulus helpers --------------------------------------
  int lat;

  task automatic cyc(input int n);
    repeat (n) @(negedge clk);
  endtask

  // One sig_i period: h cycles high, l cycles low. lat records how many
  // cycles after the rising drive valid_o was first seen (0 if never).
  task automatic drive_period(input int h, input int l);
    sig_i = 1'b1;
    lat   = 0;
    for (int i = 1; i <= h + l; i++) begin
      @(negedge clk);
      if (valid_o && lat == 0) lat = i;
      if (i == h) sig_i = 1'b0;
    end
  endtask

  // Phase 3 table: rise-to-rise periods with window boundaries.
  int p3_h[11]   = '{600, 4, 500, 500, 1, 4, 4, 4, 4, 4, 4};
  int p3_l[11]   = '{600, 4, 500, 501, 1, 4, 4, 4, 4, 4, 4};
  int p3_per[11] = '{10, 1200, 8, 1000, 1001, 2, 8, 8, 8, 8, 8};
  int p3_lng[11] = '{0, 1, 0, 0, 1, 0, 0, 0, 0, 0, 0};
  int p3_lkn[11] = '{1, 0, 0, 0, 0, 0, 0, 0, 1, 1, 1};

  int base;
  int idx;
  int hprev;

  initial begin
    // ---------------- reset state ----------------
    en = 1'b1;
    #1 rst = 1'b1;
    #2;
    check("rst_period", int'(period_o), 0);
    check("rst_high", int'(high_o), 0);
    check("rst_valid", int'(valid_o), 0);
    check("rst_errs", int'({err_short_o, err_long_o}), 0);
    check("rst_timeout", int'(timeout_o), 0);
    check("rst_locked", int'(locked_o), 0);
    cyc(2);
    rst = 1'b0;
    cyc(3);

    // ---------------- 4/4 square wave, lock ----------------
    base = vq.size();
    drive_period(4, 4);
    check("p1_first_edge_lat", lat, 0);
    drive_period(4, 4);
    check("p1_latency", lat, 3);
    for (int i = 0; i < 4; i++) drive_period(4, 4);
    check("p1_count", vq.size() - base, 5);
    for (int i = 0; i < 5; i++) begin
      idx = base + i;
      if (idx < vq.size()) begin
        check($sformatf("p1_per%0d", i), vq[idx].per, 8);
        check($sformatf("p1_err%0d", i), int'({vq[idx].es, vq[idx].el}), 0);
        check($sformatf("p1_high%0d", i), vq[idx].hi, DUTY ? 4 : 0);
        check($sformatf("p1_lkn%0d", i), int'(vq[idx].lkn), (i >= 3) ? 1 : 0);
      end
    end
    if (base + 3 < vq.size()) check("p1_lk_at_4th", int'(vq[base+3].lk), 0);

    // ---------------- 3/7 duty ----------------
    base = vq.size();
    for (int i = 0; i < 4; i++) drive_period(3, 7);
    check("p2_count", vq.size() - base, 4);
    for (int i = 0; i < 4; i++) begin
      idx = base + i;
      if (idx < vq.size()) begin
        check($sformatf("p2_per%0d", i), vq[idx].per, (i == 0) ? 8 : 10);
        check($sformatf("p2_high%0d", i), vq[idx].hi,
              DUTY ? ((i == 0) ? 4 : 3) : 0);
        check($sformatf("p2_lk%0d", i), int'(vq[idx].lk), 1);
      end
    end

    // ---------------- window errors, boundaries, relock ----------------
    base = vq.size();
    for (int i = 0; i < 11; i++) drive_period(p3_h[i], p3_l[i]);
    check("p3_count", vq.size() - base, 11);
    for (int i = 0; i < 11; i++) begin
      idx   = base + i;
      hprev = (i == 0) ? 3 : p3_h[i-1];
      if (idx < vq.size()) begin
        check($sformatf("p3_per%0d", i), vq[idx].per, p3_per[i]);
        check($sformatf("p3_long%0d", i), int'(vq[idx].el), p3_lng[i]);
        check($sformatf("p3_short%0d", i), int'(vq[idx].es), 0);
        check($sformatf("p3_lkn%0d", i), int'(vq[idx].lkn), p3_lkn[i]);
        check($sformatf("p3_high%0d", i), vq[idx].hi, DUTY ? hprev : 0);
      end
    end
    if (base + 1 < vq.size()) check("p3_lk_at_err", int'(vq[base+1].lk), 1);

    // ---------------- timeout after lock ----------------
    check("p4_locked_before", int'(locked_o), 1);
    for (int i = 0; i < 5000; i++) begin
      if (to_seen) break;
      @(negedge clk);
    end
    check("p4_to_seen", int'(to_seen), 1);
    check("p4_to_delay", to_cyc - last_valid, 4096);
    check("p4_to_locked", int'(to_lk), 0);
    base = vq.size();
    drive_period(4, 4);
    check("p4_to_cleared", int'(timeout_o), 0);
    check("p4_no_valid", vq.size() - base, 0);
    drive_period(4, 4);
    check("p4_remeasure_cnt", vq.size() - base, 1);
    if (base < vq.size()) check("p4_remeasure_per", vq[base].per, 8);

    // ---------------- enable dropped mid-period ----------------
    for (int i = 0; i < 4; i++) drive_period(4, 4);
    check("p5_locked", int'(locked_o), 1);
    sig_i = 1'b1;
    cyc(4);
    sig_i = 1'b0;
    cyc(2);
    en = 1'b0;
    cyc(2);
    check("p5_idle_locked", int'(locked_o), 0);
    check("p5_idle_hold_per", int'(period_o), 8);
    base = vq.size();
    cyc(2);
    en = 1'b1;
    cyc(2);
    drive_period(4, 4);
    check("p5_first_rise", vq.size() - base, 0);
    drive_period(4, 4);
    check("p5_second_rise", vq.size() - base, 1);
    if (base < vq.size()) check("p5_per", vq[base].per, 8);

    // ---------------- async reset mid-measurement ----------------
    sig_i = 1'b1;
    cyc(4);
    sig_i = 1'b0;
    cyc(2);
    check("p6_pre_rst_per", int'(period_o), 8);
    #2 rst = 1'b1;
    #1;
    check("p6_rst_period", int'(period_o), 0);
    check("p6_rst_locked", int'(locked_o), 0);
    check("p6_rst_flags", int'({valid_o, err_short_o, err_long_o, timeout_o}), 0);
    check("p6_rst_high", int'(high_o), 0);
    @(negedge clk);
    #3 rst = 1'b0;
    base = vq.size();
    cyc(4);
    drive_period(4, 4);
    check("p6_first_rise", vq.size() - base, 0);
    drive_period(4, 4);
    check("p6_second_rise", vq.size() - base, 1);
    if (base < vq.size()) check("p6_per", vq[base].per, 8);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
